// File: rtl/aes_round_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_round_engine : iterative AES encryption core, one round per clock.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module aes_round_engine #(
    parameter int NUM_ROUNDS = 14
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic         Key_Ready,
    input  logic [127:0] Plain_In,
    input  logic [127:0] Key_In,
    output logic [3:0]   Addr_Key,
    output logic         Busy,
    output logic         Done,
    output logic [127:0] Cipher_Out
);

    localparam logic [3:0] c_LAST = 4'(NUM_ROUNDS);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t         r_fsm;
    logic [3:0]     r_cnt;
    logic [127:0]   r_state;
    logic           r_busy;
    logic           r_done;
    logic [127:0]   w_sr;
    logic [127:0]   w_mc;

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return c_SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] f_xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row r, column c) lives at bit offset 32c + 24 - 8r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[32*c+24-8*r +: 8] = f_sbox(r_state[32*((c+r)%4)+24-8*r +: 8]);
            assign w_mc[32*c+24-8*r +: 8] =
                f_xt(w_sr[32*c+24-8*r +: 8]) ^
                f_xt(w_sr[32*c+24-8*((r+1)%4) +: 8]) ^ w_sr[32*c+24-8*((r+1)%4) +: 8] ^
                w_sr[32*c+24-8*((r+2)%4) +: 8] ^ w_sr[32*c+24-8*((r+3)%4) +: 8];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_fsm      <= IDLE;
            r_cnt      <= 4'd0;
            r_state    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            Cipher_Out <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (Start && Key_Ready) begin
                        r_state <= Plain_In ^ Key_In;
                        r_cnt   <= 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    if (r_cnt == c_LAST) begin
                        r_state    <= w_sr ^ Key_In;
                        Cipher_Out <= w_sr ^ Key_In;
                        r_done     <= 1'b1;
                        r_fsm      <= FINISH;
                    end else begin
                        r_state <= w_mc ^ Key_In;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                FINISH: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_cnt  <= 4'd0;
                    r_fsm  <= IDLE;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_cnt  <= 4'd0;
                    r_fsm  <= IDLE;
                end
            endcase
        end
    end

    // The counter is zero whenever the engine is idle, so it doubles as the key address.
    assign Addr_Key = r_cnt;
    assign Busy     = r_busy;
    assign Done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_round_engine : randomized bench for aes_round_engine with a         |
// | byte-array AES-256 reference model and a behavioural key store.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_aes_round_engine;

    localparam int c_NR = 14;

    logic         Clk       = 1'b0;
    logic         Rst       = 1'b0;
    logic         Start     = 1'b0;
    logic         Key_Ready = 1'b0;
    logic [127:0] Plain_In  = '0;
    logic [127:0] Key_In;
    logic [3:0]   Addr_Key;
    logic         Busy;
    logic         Done;
    logic [127:0] Cipher_Out;

    logic [127:0] rk   [0:15];
    logic [7:0]   sbox [0:255];
    int           n_checks = 0;
    int           n_fail   = 0;

    localparam logic [255:0] c_KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_PT_C3  = 128'hccddeeff_8899aabb_44556677_00112233;
    localparam logic [127:0] c_CT_C3  = 128'h4b496089_eafc4990_516745bf_8ea2b7ca;
    localparam logic [127:0] c_CT_Z   = 128'h92842087_ad48a214_a2408989_dc95c078;

    assign Key_In = rk[Addr_Key];

    aes_round_engine #(.NUM_ROUNDS(c_NR)) u_dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .Key_Ready  (Key_Ready),
        .Plain_In   (Plain_In),
        .Key_In     (Key_In),
        .Addr_Key   (Addr_Key),
        .Busy       (Busy),
        .Done       (Done),
        .Cipher_Out (Cipher_Out)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) rk[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
        rk[15] = '0;
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] out;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[32*c+24-8*r +: 8] ^ rk[0][32*c+24-8*r +: 8];
        for (int k = 1; k <= c_NR; k++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (k < c_NR)
                        s[r][c] = gf_mul(8'h02, t[r][c]) ^ gf_mul(8'h03, t[(r+1)%4][c]) ^
                                  t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ rk[k][32*c+24-8*r +: 8];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[32*c+24-8*r +: 8] = s[r][c];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode: 0 plain, 1 Start+new data at round 5, 2 Key_Ready drop, 3 Start in FINISH
    task automatic run_block(input string tag, input logic [127:0] pt, input int mode);
        logic [127:0] exp;
        exp       = model_enc(pt);
        Plain_In  = pt;
        Start     = 1'b1;
        Key_Ready = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 1; k <= c_NR; k++) begin
            check_eq($sformatf("%s.addr%0d", tag, k), 128'(Addr_Key), 128'(k));
            check_eq($sformatf("%s.busy%0d", tag, k), 128'(Busy), 128'(1));
            check_eq($sformatf("%s.done%0d", tag, k), 128'(Done), 128'(0));
            if (mode == 1 && k == 5) begin
                Start    = 1'b1;
                Plain_In = ~pt;
            end
            if (mode == 1 && k == 6) Start = 1'b0;
            if (mode == 2 && k == 3) Key_Ready = 1'b0;
            tick();
        end
        check_eq({tag, ".done"}, 128'(Done), 128'(1));
        check_eq({tag, ".busy_fin"}, 128'(Busy), 128'(1));
        check_eq({tag, ".cipher"}, Cipher_Out, exp);
        if (mode == 3) Start = 1'b1;
        tick();
        Start = 1'b0;
        check_eq({tag, ".idle_busy"}, 128'(Busy), 128'(0));
        check_eq({tag, ".idle_done"}, 128'(Done), 128'(0));
        check_eq({tag, ".idle_addr"}, 128'(Addr_Key), 128'(0));
        check_eq({tag, ".hold"}, Cipher_Out, exp);
        tick();
        check_eq({tag, ".idle2_busy"}, 128'(Busy), 128'(0));
        Plain_In  = pt;
        Key_Ready = 1'b1;
    endtask

    initial begin
        logic [127:0] pt;
        logic [127:0] cur;
        logic [127:0] nxt;
        build_sbox();
        load_key(c_KEY_C3);

        // Reset dominates even with a valid request present.
        Start     = 1'b1;
        Key_Ready = 1'b1;
        Plain_In  = c_PT_C3;
        tick();
        tick();
        check_eq("rst.busy", 128'(Busy), 128'(0));
        check_eq("rst.done", 128'(Done), 128'(0));
        check_eq("rst.addr", 128'(Addr_Key), 128'(0));
        check_eq("rst.cipher", Cipher_Out, 128'(0));
        Start = 1'b0;
        Rst   = 1'b1;

        run_block("c3", c_PT_C3, 0);
        check_eq("c3.kat", Cipher_Out, c_CT_C3);

        Start     = 1'b1;
        Key_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("nokey.busy%0d", i), 128'(Busy), 128'(0));
            check_eq($sformatf("nokey.addr%0d", i), 128'(Addr_Key), 128'(0));
            check_eq($sformatf("nokey.done%0d", i), 128'(Done), 128'(0));
        end
        run_block("nokey_run", c_PT_C3, 0);

        run_block("ign", c_PT_C3, 1);
        check_eq("ign.kat", Cipher_Out, c_CT_C3);
        run_block("krdrop", rand128(), 2);
        run_block("finstart", rand128(), 3);

        // Reset in round 7 abandons the block.
        Plain_In = c_PT_C3;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("mid.addr7", 128'(Addr_Key), 128'(7));
        #2;
        Rst = 1'b0;
        #1;
        check_eq("mid.busy", 128'(Busy), 128'(0));
        check_eq("mid.done", 128'(Done), 128'(0));
        check_eq("mid.addr", 128'(Addr_Key), 128'(0));
        check_eq("mid.cipher", Cipher_Out, 128'(0));
        tick();
        tick();
        Rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq($sformatf("mid.nodone%0d", i), 128'({Busy, Done}), 128'(0));
        end
        run_block("c3_again", c_PT_C3, 0);
        check_eq("c3_again.kat", Cipher_Out, c_CT_C3);

        load_key(256'h0);
        run_block("zero", 128'h0, 0);
        check_eq("zero.kat", Cipher_Out, c_CT_Z);

        for (int n = 0; n < 4; n++) begin
            load_key({rand128(), rand128()});
            run_block($sformatf("rnd%0d", n), rand128(), 0);
        end

        // Start held high: one block per 16 cycles, single idle cycle between.
        pt       = rand128();
        Plain_In = pt;
        Start    = 1'b1;
        cur      = pt;
        nxt      = pt;
        tick();
        for (int k = 1; k <= 48; k++) begin
            if (k % 16 == 8) begin
                nxt      = rand128();
                Plain_In = nxt;
            end
            check_eq($sformatf("hold.done%0d", k), 128'(Done), 128'(k % 16 == 15));
            check_eq($sformatf("hold.busy%0d", k), 128'(Busy), 128'(k % 16 != 0));
            if (k % 16 == 15) check_eq($sformatf("hold.cipher%0d", k), Cipher_Out, model_enc(cur));
            if (k % 16 == 0) cur = nxt;
            tick();
        end
        Start = 1'b0;
        for (int i = 0; i < 16; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
